// File: rtl/pe_seq_pkg.sv
// Shared types and widths for the PE multiply-accumulate sequencer.
package pe_seq_pkg;

    localparam int unsigned MAC_CNT_W  = 8;
    localparam int unsigned WAIT_CNT_W = 10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        LOAD  = 3'd2,
        MUL   = 3'd3,
        WAIT  = 3'd4,
        ACC   = 3'd5,
        DONE  = 3'd6,
        ERR   = 3'd7
    } seq_state_e;

endpackage

// File: rtl/pe_wait_timer.sv
// Counts cycles spent waiting on the multiplier; flags the last permitted cycle.
module pe_wait_timer
    import pe_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  enable,
    output logic [WAIT_CNT_W-1:0] wait_cnt,
    output logic                  expired
);

    localparam logic [WAIT_CNT_W-1:0] CNT_LAST = WAIT_CNT_W'(TIMEOUT - 1);

    logic [WAIT_CNT_W-1:0] cnt_d;

    // Saturates at the compare value so the count never wraps.
    always_comb begin
        cnt_d = wait_cnt;
        if (load) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = wait_cnt + WAIT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            expired  <= 1'b0;
        end else begin
            wait_cnt <= cnt_d;
            expired  <= (cnt_d == CNT_LAST);
        end
    end

endmodule

// File: rtl/pe_mac_sequencer.sv
// Control FSM sequencing one systolic-array PE through a NUM_MAC-term multiply-accumulate.
module pe_mac_sequencer
    import pe_seq_pkg::*;
#(
    parameter int unsigned NUM_MAC = 2,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic op_valid,
    output logic op_ready,
    input  logic delayed_done,
    output logic act_BOOTH,
    output logic clr_result_PIPO,
    output logic clr_in_exp_PIPO,
    output logic clr_status_reg,
    output logic load_in_exp_PIPO,
    output logic busy,
    output logic result_valid,
    output logic err
);

    localparam logic [MAC_CNT_W-1:0] MAC_LAST = MAC_CNT_W'(NUM_MAC);

    seq_state_e            state_q;
    seq_state_e            state_d;
    logic [MAC_CNT_W-1:0]  mac_cnt_q;
    logic [MAC_CNT_W-1:0]  mac_cnt_d;
    logic                  err_d;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  wait_expired;

    pe_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (state_q == MUL),
        .enable  (state_q == WAIT),
        .wait_cnt(wait_cnt),
        .expired (wait_expired)
    );

    // Operand registers load in the same cycle the feeder handshakes.
    assign load_in_exp_PIPO = op_valid & op_ready;

    always_comb begin
        state_d   = state_q;
        mac_cnt_d = mac_cnt_q;
        err_d     = err;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = CLEAR;
                    mac_cnt_d = '0;
                    err_d     = 1'b0;
                end
            end
            CLEAR: state_d = LOAD;
            LOAD: begin
                if (op_valid && op_ready) begin
                    state_d = MUL;
                end
            end
            MUL: state_d = WAIT;
            WAIT: begin
                // A done arriving on the last permitted cycle still counts.
                if (delayed_done) begin
                    state_d = ACC;
                end else if (wait_expired) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end
            end
            ACC: begin
                mac_cnt_d = mac_cnt_q + MAC_CNT_W'(1);
                state_d   = (mac_cnt_d == MAC_LAST) ? DONE : LOAD;
            end
            DONE: state_d = IDLE;
            ERR: begin
                if (start) begin
                    state_d   = CLEAR;
                    mac_cnt_d = '0;
                    err_d     = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            mac_cnt_q       <= '0;
            err             <= 1'b0;
            op_ready        <= 1'b0;
            act_BOOTH       <= 1'b0;
            clr_result_PIPO <= 1'b0;
            clr_in_exp_PIPO <= 1'b0;
            clr_status_reg  <= 1'b0;
            busy            <= 1'b0;
            result_valid    <= 1'b0;
        end else begin
            state_q         <= state_d;
            mac_cnt_q       <= mac_cnt_d;
            err             <= err_d;
            op_ready        <= (state_d == LOAD);
            act_BOOTH       <= (state_d == MUL);
            clr_result_PIPO <= (state_d == CLEAR);
            clr_in_exp_PIPO <= (state_d == CLEAR) || (state_d == ERR);
            clr_status_reg  <= (state_d == CLEAR) || (state_d == ERR);
            busy            <= (state_d != IDLE);
            result_valid    <= (state_d == DONE);
        end
    end

    wait_cnt_bounded: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == WAIT) |-> (wait_cnt < WAIT_CNT_W'(TIMEOUT)));

endmodule
